// File: rtl/alu_slot_ctrl_pkg.sv
// Shared slot-state encoding, slot count and index helpers for the ALU slot tracker.
// Optional protocol checking in alu_slot_ctrl is enabled with the ALU_SLOT_CHECK_EN macro.
package alu_slot_ctrl_pkg;

    localparam int         NUM_SLOTS = 6;
    localparam logic [2:0] NO_SLOT   = 3'b111;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'b00,
        SLOT_WAIT  = 2'b01,
        SLOT_READY = 2'b10,
        SLOT_EXEC  = 2'b11
    } slot_state_e;

    function automatic logic idx_valid(input logic [2:0] idx);
        return idx < 3'(NUM_SLOTS);
    endfunction

    // Out-of-range codes (including NO_SLOT) decode to an all-zero vector.
    function automatic logic [NUM_SLOTS-1:0] idx_onehot(input logic [2:0] idx);
        logic [NUM_SLOTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == 3'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/alu_slot_fsm.sv
// Four-state lifecycle of a single ALU issue slot, driven by pre-qualified strobes.
module alu_slot_fsm
    import alu_slot_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        alloc,
    input  logic        alloc_rdy,
    input  logic        wake,
    input  logic        disp,
    input  logic        cmpl,
    output slot_state_e state
);

    slot_state_e state_q;
    slot_state_e state_d;

    always_comb begin
        state_d = state_q;
        if (!rdy) begin
            state_d = state_q;
        end else if (flush) begin
            state_d = SLOT_FREE;
        end else begin
            case (state_q)
                SLOT_FREE: begin
                    if (alloc) begin
                        state_d = (alloc_rdy || wake) ? SLOT_READY : SLOT_WAIT;
                    end
                end
                SLOT_WAIT: begin
                    if (wake) begin
                        state_d = SLOT_READY;
                    end
                end
                SLOT_READY: begin
                    if (disp) begin
                        state_d = SLOT_EXEC;
                    end
                end
                SLOT_EXEC: begin
                    if (cmpl) begin
                        state_d = SLOT_FREE;
                    end
                end
                default: state_d = SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/alu_slot_ctrl.sv
// Tracks the six ALU issue slots: index decode, port conflict resolution, issue registers, error flag.
// Define ALU_SLOT_CHECK_EN to make protocol violations set the sticky err output.
module alu_slot_ctrl
    import alu_slot_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 alloc_en_1,
    input  logic                 alloc_en_2,
    input  logic [2:0]           alloc_idx_1,
    input  logic [2:0]           alloc_idx_2,
    input  logic                 alloc_rdy_1,
    input  logic                 alloc_rdy_2,
    input  logic [NUM_SLOTS-1:0] wake_vec,
    input  logic [2:0]           disp_idx_1,
    input  logic [2:0]           disp_idx_2,
    input  logic                 cmpl_valid,
    input  logic [2:0]           cmpl_slot,
    output logic [NUM_SLOTS-1:0] alu_busy,
    output logic [NUM_SLOTS-1:0] alu_ready,
    output logic                 issue_valid_1,
    output logic                 issue_valid_2,
    output logic [2:0]           issue_slot_1,
    output logic [2:0]           issue_slot_2,
    output logic                 full,
    output logic                 err
);

    slot_state_e          slot_state [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] is_free;
    logic [NUM_SLOTS-1:0] is_ready;
    logic [NUM_SLOTS-1:0] is_exec;

    always_comb begin
        is_free  = '0;
        is_ready = '0;
        is_exec  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            is_free[i]  = (slot_state[i] == SLOT_FREE);
            is_ready[i] = (slot_state[i] == SLOT_READY);
            is_exec[i]  = (slot_state[i] == SLOT_EXEC);
        end
    end

    assign alu_busy  = ~is_free;
    assign alu_ready = ~is_ready;
    assign full      = &alu_busy;

    logic                 alloc_same;
    logic                 disp_same;
    logic [NUM_SLOTS-1:0] alloc_oh_1;
    logic [NUM_SLOTS-1:0] alloc_oh_2;
    logic [NUM_SLOTS-1:0] disp_oh_1;
    logic [NUM_SLOTS-1:0] disp_oh_2;
    logic [NUM_SLOTS-1:0] alloc_hit_1;
    logic [NUM_SLOTS-1:0] alloc_hit_2;
    logic [NUM_SLOTS-1:0] slot_alloc;
    logic [NUM_SLOTS-1:0] slot_alloc_rdy;
    logic [NUM_SLOTS-1:0] slot_disp;
    logic [NUM_SLOTS-1:0] slot_cmpl;
    logic                 disp_ok_1;
    logic                 disp_ok_2;

    // On a shared target index port 1 wins; the port 2 request is dropped entirely.
    always_comb begin
        alloc_same     = alloc_en_1 && alloc_en_2 && idx_valid(alloc_idx_1)
                         && (alloc_idx_1 == alloc_idx_2);
        disp_same      = idx_valid(disp_idx_1) && (disp_idx_1 == disp_idx_2);
        alloc_oh_1     = alloc_en_1 ? idx_onehot(alloc_idx_1) : '0;
        alloc_oh_2     = (alloc_en_2 && !alloc_same) ? idx_onehot(alloc_idx_2) : '0;
        disp_oh_1      = idx_onehot(disp_idx_1);
        disp_oh_2      = disp_same ? '0 : idx_onehot(disp_idx_2);
        alloc_hit_1    = alloc_oh_1 & is_free;
        alloc_hit_2    = alloc_oh_2 & is_free;
        slot_alloc     = alloc_hit_1 | alloc_hit_2;
        slot_alloc_rdy = (alloc_hit_1 & {NUM_SLOTS{alloc_rdy_1}})
                       | (alloc_hit_2 & {NUM_SLOTS{alloc_rdy_2}});
        slot_disp      = (disp_oh_1 | disp_oh_2) & is_ready;
        slot_cmpl      = (cmpl_valid ? idx_onehot(cmpl_slot) : '0) & is_exec;
        disp_ok_1      = |(disp_oh_1 & is_ready);
        disp_ok_2      = |(disp_oh_2 & is_ready);
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        alu_slot_fsm u_fsm (
            .clk       (clk),
            .rst       (rst),
            .rdy       (rdy),
            .flush     (flush),
            .alloc     (slot_alloc[g]),
            .alloc_rdy (slot_alloc_rdy[g]),
            .wake      (wake_vec[g]),
            .disp      (slot_disp[g]),
            .cmpl      (slot_cmpl[g]),
            .state     (slot_state[g])
        );
    end

    logic       issue_valid_1_q, issue_valid_1_d;
    logic       issue_valid_2_q, issue_valid_2_d;
    logic [2:0] issue_slot_1_q, issue_slot_1_d;
    logic [2:0] issue_slot_2_q, issue_slot_2_d;

    always_comb begin
        issue_valid_1_d = rdy && !flush && disp_ok_1;
        issue_valid_2_d = rdy && !flush && disp_ok_2;
        issue_slot_1_d  = issue_valid_1_d ? disp_idx_1 : NO_SLOT;
        issue_slot_2_d  = issue_valid_2_d ? disp_idx_2 : NO_SLOT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_1_q <= 1'b0;
            issue_valid_2_q <= 1'b0;
            issue_slot_1_q  <= NO_SLOT;
            issue_slot_2_q  <= NO_SLOT;
        end else begin
            issue_valid_1_q <= issue_valid_1_d;
            issue_valid_2_q <= issue_valid_2_d;
            issue_slot_1_q  <= issue_slot_1_d;
            issue_slot_2_q  <= issue_slot_2_d;
        end
    end

    assign issue_valid_1 = issue_valid_1_q;
    assign issue_valid_2 = issue_valid_2_q;
    assign issue_slot_1  = issue_slot_1_q;
    assign issue_slot_2  = issue_slot_2_q;

`ifdef ALU_SLOT_CHECK_EN
    logic illegal;
    logic err_q, err_d;

    // Violations are only recorded on cycles where per-slot events could actually apply.
    always_comb begin
        illegal = (alloc_en_1 && idx_valid(alloc_idx_1) && !(|alloc_hit_1))
                | (alloc_en_2 && !alloc_same && idx_valid(alloc_idx_2) && !(|alloc_hit_2))
                | alloc_same
                | disp_same
                | (idx_valid(disp_idx_1) && !disp_ok_1)
                | (idx_valid(disp_idx_2) && !disp_same && !disp_ok_2)
                | (cmpl_valid && !(|slot_cmpl));
        err_d = err_q;
        if (rdy && !flush && illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_slot_ctrl.sv
// Self-checking bench for alu_slot_ctrl; issue expectations flow through a scoreboard queue.
module tb_alu_slot_ctrl;

    localparam logic [2:0] NO_SLOT = 3'b111;
`ifdef ALU_SLOT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic       v1;
        logic [2:0] s1;
        logic       v2;
        logic [2:0] s2;
    } issue_t;

    logic       clk = 1'b0;
    logic       rst, rdy, flush;
    logic       alloc_en_1, alloc_en_2, alloc_rdy_1, alloc_rdy_2;
    logic [2:0] alloc_idx_1, alloc_idx_2, disp_idx_1, disp_idx_2, cmpl_slot;
    logic [5:0] wake_vec;
    logic       cmpl_valid;
    logic [5:0] alu_busy, alu_ready;
    logic       issue_valid_1, issue_valid_2, full, err;
    logic [2:0] issue_slot_1, issue_slot_2;

    issue_t exp_q[$];
    int     checks = 0;
    int     passed = 0;

    always #5 clk = ~clk;

    alu_slot_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .alloc_en_1    (alloc_en_1),
        .alloc_en_2    (alloc_en_2),
        .alloc_idx_1   (alloc_idx_1),
        .alloc_idx_2   (alloc_idx_2),
        .alloc_rdy_1   (alloc_rdy_1),
        .alloc_rdy_2   (alloc_rdy_2),
        .wake_vec      (wake_vec),
        .disp_idx_1    (disp_idx_1),
        .disp_idx_2    (disp_idx_2),
        .cmpl_valid    (cmpl_valid),
        .cmpl_slot     (cmpl_slot),
        .alu_busy      (alu_busy),
        .alu_ready     (alu_ready),
        .issue_valid_1 (issue_valid_1),
        .issue_valid_2 (issue_valid_2),
        .issue_slot_1  (issue_slot_1),
        .issue_slot_2  (issue_slot_2),
        .full          (full),
        .err           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; flush = 1'b0;
        alloc_en_1 = 1'b0; alloc_en_2 = 1'b0; alloc_rdy_1 = 1'b0; alloc_rdy_2 = 1'b0;
        alloc_idx_1 = NO_SLOT; alloc_idx_2 = NO_SLOT;
        disp_idx_1 = NO_SLOT; disp_idx_2 = NO_SLOT;
        wake_vec = 6'b0; cmpl_valid = 1'b0; cmpl_slot = NO_SLOT;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (alu_busy !== 6'b000000) $display("FAIL reset_busy: got %b want 000000", alu_busy); else passed++;
        checks++; if (alu_ready !== 6'b111111) $display("FAIL reset_ready: got %b want 111111", alu_ready); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
        checks++; if ({issue_valid_1, issue_valid_2} !== 2'b00) $display("FAIL reset_issue_valid: got %b want 00", {issue_valid_1, issue_valid_2}); else passed++;
        checks++; if ({issue_slot_1, issue_slot_2} !== {NO_SLOT, NO_SLOT}) $display("FAIL reset_issue_slot: got %b %b want 111 111", issue_slot_1, issue_slot_2); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_alloc_wake();
        alloc_en_1 = 1'b1; alloc_idx_1 = 3'd0; alloc_rdy_1 = 1'b1;
        alloc_en_2 = 1'b1; alloc_idx_2 = 3'd1; alloc_rdy_2 = 1'b0;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b000011) $display("FAIL alloc_busy: got %b want 000011", alu_busy); else passed++;
        checks++; if (alu_ready !== 6'b111110) $display("FAIL alloc_ready: got %b want 111110", alu_ready); else passed++;
        wake_vec = 6'b000010;
        tick();
        idle_inputs();
        checks++; if (alu_ready !== 6'b111100) $display("FAIL wake_ready: got %b want 111100", alu_ready); else passed++;
        checks++; if (alu_busy !== 6'b000011) $display("FAIL wake_busy: got %b want 000011", alu_busy); else passed++;
    endtask

    task automatic test_dispatch_complete();
        issue_t e;
        disp_idx_1 = 3'd0; disp_idx_2 = 3'd1;
        exp_q.push_back('{v1: 1'b1, s1: 3'd0, v2: 1'b1, s2: 3'd1});
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++; if (issue_valid_1 !== e.v1 || issue_slot_1 !== e.s1) $display("FAIL disp_port1: got %b/%0d want %b/%0d", issue_valid_1, issue_slot_1, e.v1, e.s1); else passed++;
        checks++; if (issue_valid_2 !== e.v2 || issue_slot_2 !== e.s2) $display("FAIL disp_port2: got %b/%0d want %b/%0d", issue_valid_2, issue_slot_2, e.v2, e.s2); else passed++;
        checks++; if (alu_ready !== 6'b111111) $display("FAIL disp_ready: got %b want 111111", alu_ready); else passed++;
        cmpl_valid = 1'b1; cmpl_slot = 3'd0;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b000010) $display("FAIL cmpl_busy: got %b want 000010", alu_busy); else passed++;
        checks++; if (issue_valid_1 !== 1'b0) $display("FAIL disp_one_shot: got %b want 0", issue_valid_1); else passed++;
        cmpl_valid = 1'b1; cmpl_slot = 3'd1;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b000000) $display("FAIL cmpl_all_busy: got %b want 000000", alu_busy); else passed++;
    endtask

    task automatic test_full_err();
        for (int k = 0; k < 3; k++) begin
            alloc_en_1 = 1'b1; alloc_idx_1 = 3'(2 * k);
            alloc_en_2 = 1'b1; alloc_idx_2 = 3'(2 * k + 1);
            tick();
            idle_inputs();
        end
        checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else passed++;
        checks++; if (alu_ready !== 6'b111111) $display("FAIL full_all_wait: got %b want 111111", alu_ready); else passed++;
        alloc_en_1 = 1'b1; alloc_idx_1 = NO_SLOT; alloc_rdy_1 = 1'b1;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b111111 || alu_ready !== 6'b111111) $display("FAIL noslot_state: got %b/%b want 111111/111111", alu_busy, alu_ready); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL noslot_err: got %b want 0", err); else passed++;
        alloc_en_1 = 1'b1; alloc_idx_1 = 3'd3; alloc_rdy_1 = 1'b1;
        tick();
        idle_inputs();
        checks++; if (alu_ready !== 6'b111111) $display("FAIL busy_alloc_ignored: got %b want 111111", alu_ready); else passed++;
        checks++; if (err !== EXP_ERR) $display("FAIL busy_alloc_err: got %b want %b", err, EXP_ERR); else passed++;
        tick();
        checks++; if (err !== EXP_ERR) $display("FAIL err_sticky: got %b want %b", err, EXP_ERR); else passed++;
        wake_vec = 6'b111111;
        tick();
        idle_inputs();
        checks++; if (alu_ready !== 6'b000000) $display("FAIL wake_all: got %b want 000000", alu_ready); else passed++;
    endtask

    task automatic test_rdy_freeze();
        issue_t e;
        for (int k = 0; k < 3; k++) begin
            rdy = 1'b0; disp_idx_1 = 3'd0; disp_idx_2 = 3'd1;
            exp_q.push_back('{v1: 1'b0, s1: NO_SLOT, v2: 1'b0, s2: NO_SLOT});
            tick();
            e = exp_q.pop_front();
            checks++; if ({issue_valid_1, issue_valid_2} !== {e.v1, e.v2}) $display("FAIL freeze_issue: got %b want %b", {issue_valid_1, issue_valid_2}, {e.v1, e.v2}); else passed++;
            checks++; if (alu_ready !== 6'b000000) $display("FAIL freeze_state: got %b want 000000", alu_ready); else passed++;
        end
        rdy = 1'b1;
        exp_q.push_back('{v1: 1'b1, s1: 3'd0, v2: 1'b1, s2: 3'd1});
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++; if (issue_valid_1 !== e.v1 || issue_slot_1 !== e.s1 || issue_valid_2 !== e.v2 || issue_slot_2 !== e.s2) $display("FAIL resume_issue: got %b/%0d %b/%0d want %b/%0d %b/%0d", issue_valid_1, issue_slot_1, issue_valid_2, issue_slot_2, e.v1, e.s1, e.v2, e.s2); else passed++;
        checks++; if (alu_ready !== 6'b000011) $display("FAIL resume_ready: got %b want 000011", alu_ready); else passed++;
        disp_idx_1 = 3'd2; disp_idx_2 = 3'd2;
        exp_q.push_back('{v1: 1'b1, s1: 3'd2, v2: 1'b0, s2: NO_SLOT});
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++; if (issue_valid_1 !== e.v1 || issue_slot_1 !== e.s1 || issue_valid_2 !== e.v2) $display("FAIL dup_disp: got %b/%0d %b want %b/%0d %b", issue_valid_1, issue_slot_1, issue_valid_2, e.v1, e.s1, e.v2); else passed++;
        checks++; if (alu_ready !== 6'b000111) $display("FAIL dup_disp_ready: got %b want 000111", alu_ready); else passed++;
    endtask

    task automatic test_flush();
        cmpl_valid = 1'b1; cmpl_slot = 3'd0;
        tick();
        idle_inputs();
        alloc_en_1 = 1'b1; alloc_idx_1 = 3'd0;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b111111 || alu_ready !== 6'b000111) $display("FAIL preflush_mix: got %b/%b want 111111/000111", alu_busy, alu_ready); else passed++;
        flush = 1'b1; disp_idx_1 = 3'd3;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b000000 || alu_ready !== 6'b111111) $display("FAIL flush_state: got %b/%b want 000000/111111", alu_busy, alu_ready); else passed++;
        checks++; if ({issue_valid_1, issue_valid_2} !== 2'b00) $display("FAIL flush_issue: got %b want 00", {issue_valid_1, issue_valid_2}); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL flush_full: got %b want 0", full); else passed++;
        checks++; if (err !== EXP_ERR) $display("FAIL flush_keeps_err: got %b want %b", err, EXP_ERR); else passed++;
    endtask

    task automatic test_back_to_back();
        issue_t e;
        alloc_en_1 = 1'b1; alloc_idx_1 = 3'd4; alloc_rdy_1 = 1'b1;
        tick();
        idle_inputs();
        checks++; if (alu_ready !== 6'b101111) $display("FAIL b2b_alloc_ready: got %b want 101111", alu_ready); else passed++;
        disp_idx_2 = 3'd4;
        exp_q.push_back('{v1: 1'b0, s1: NO_SLOT, v2: 1'b1, s2: 3'd4});
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++; if (issue_valid_1 !== e.v1 || issue_valid_2 !== e.v2 || issue_slot_2 !== e.s2) $display("FAIL b2b_issue: got %b %b/%0d want %b %b/%0d", issue_valid_1, issue_valid_2, issue_slot_2, e.v1, e.v2, e.s2); else passed++;
        cmpl_valid = 1'b1; cmpl_slot = 3'd4;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b000000) $display("FAIL b2b_cmpl: got %b want 000000", alu_busy); else passed++;
        alloc_en_1 = 1'b1; alloc_idx_1 = 3'd4;
        alloc_en_2 = 1'b1; alloc_idx_2 = 3'd2; wake_vec = 6'b000100;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b010100 || alu_ready !== 6'b111011) $display("FAIL realloc_wake: got %b/%b want 010100/111011", alu_busy, alu_ready); else passed++;
        alloc_en_1 = 1'b1; alloc_idx_1 = 3'd5; alloc_rdy_1 = 1'b0;
        alloc_en_2 = 1'b1; alloc_idx_2 = 3'd5; alloc_rdy_2 = 1'b1;
        tick();
        idle_inputs();
        checks++; if (alu_busy !== 6'b110100 || alu_ready !== 6'b111011) $display("FAIL dup_alloc: got %b/%b want 110100/111011", alu_busy, alu_ready); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (alu_busy !== 6'b000000 || alu_ready !== 6'b111111 || err !== 1'b0) $display("FAIL mid_reset: got %b/%b/%b want 000000/111111/0", alu_busy, alu_ready, err); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alloc_wake();
        test_dispatch_complete();
        test_full_err();
        test_rdy_freeze();
        test_flush();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
